// File: rtl/axi_defs_pkg.sv
// Shared AXI definitions for the burst memory slave.
//   - response codes (OKAY / SLVERR)
//   - burst type codes (FIXED / INCR / WRAP)
//   - state encoding of the slave control FSM
package axi_defs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_FETCH,
        ST_RD_SEND
    } slave_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address / beat tracker shared by the read and write paths.
// Ports:
//   i_axi_clk, i_axi_rst   clock, synchronous active-low reset
//   load, load_*           latch start word address, length, burst type, error flag
//   step                   advance one beat
//   set_err                raise the sticky error flag (protocol violation)
//   addr                   current RAM word address
//   addr_next              address the next step will produce
//   last                   current beat is beat number len
//   over                   beats have been consumed beyond len
//   err                    sticky error flag for the current transaction
module axi_burst_addr_gen
    import axi_defs_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      i_axi_clk,
    input  logic                      i_axi_rst,
    input  logic                      load,
    input  logic [MEM_ADDR_WIDTH-1:0] load_addr,
    input  logic [7:0]                load_len,
    input  logic [1:0]                load_burst,
    input  logic                      load_err,
    input  logic                      step,
    input  logic                      set_err,
    output logic [MEM_ADDR_WIDTH-1:0] addr,
    output logic [MEM_ADDR_WIDTH-1:0] addr_next,
    output logic                      last,
    output logic                      over,
    output logic                      err
);

    logic [7:0] len_q;
    logic [7:0] beat_q;
    logic [1:0] burst_q;

    // Only INCR moves; FIXED and the error bursts hold the address.
    // Natural overflow wraps modulo the RAM depth.
    assign addr_next = (burst_q == BURST_INCR) ? addr + MEM_ADDR_WIDTH'(1) : addr;
    assign last      = (beat_q == len_q) & ~over;

    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            addr    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            over    <= 1'b0;
            err     <= 1'b0;
        end else if (load) begin
            addr    <= load_addr;
            len_q   <= load_len;
            beat_q  <= '0;
            burst_q <= load_burst;
            over    <= 1'b0;
            err     <= load_err;
        end else begin
            if (step) begin
                addr <= addr_next;
                // Beat counter saturates at len; further beats only mark "over".
                if (beat_q == len_q) begin
                    over <= 1'b1;
                end else begin
                    beat_q <= beat_q + 8'd1;
                end
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst slave in front of a single-port synchronous RAM (1-cycle read
// latency). One transaction in flight; reads and writes alternate on ties.
// Ports:
//   i_axi_clk, i_axi_rst       clock, synchronous active-low reset
//   axi_aw*, axi_w*, axi_b*    AXI write address / data / response channels
//   axi_ar*, axi_r*            AXI read address / data channels
//   o_mem_wen                  per-byte RAM write enable (one-cycle pulse per beat)
//   o_mem_addr, o_mem_wdata    RAM word address and write data
//   i_mem_rdata                RAM read data, valid one cycle after o_mem_addr
module axi_burst_mem_slave
    import axi_defs_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                      i_axi_clk,
    input  logic                      i_axi_rst,
    // write address
    input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
    input  logic [ID_WIDTH-1:0]       axi_awid,
    input  logic [7:0]                axi_awlen,
    input  logic [2:0]                axi_awsize,
    input  logic [1:0]                axi_awburst,
    input  logic                      axi_awvalid,
    output logic                      axi_awready,
    // write data
    input  logic [DATA_WIDTH-1:0]     axi_wdata,
    input  logic [ID_WIDTH-1:0]       axi_wid,
    input  logic [STRB_WIDTH-1:0]     axi_wstrb,
    input  logic                      axi_wlast,
    input  logic                      axi_wvalid,
    output logic                      axi_wready,
    // write response
    output logic [1:0]                axi_bresp,
    output logic [ID_WIDTH-1:0]       axi_bid,
    output logic                      axi_bvalid,
    input  logic                      axi_bready,
    // read address
    input  logic [ADDR_WIDTH-1:0]     axi_araddr,
    input  logic [ID_WIDTH-1:0]       axi_arid,
    input  logic [7:0]                axi_arlen,
    input  logic [2:0]                axi_arsize,
    input  logic [1:0]                axi_arburst,
    input  logic                      axi_arvalid,
    output logic                      axi_arready,
    // read data
    output logic [DATA_WIDTH-1:0]     axi_rdata,
    output logic [ID_WIDTH-1:0]       axi_rid,
    output logic [1:0]                axi_rresp,
    output logic                      axi_rlast,
    output logic                      axi_rvalid,
    input  logic                      axi_rready,
    // local RAM
    output logic [STRB_WIDTH-1:0]     o_mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

    localparam int         ADDR_LSB  = $clog2(STRB_WIDTH);
    localparam logic [2:0] FULL_SIZE = 3'(ADDR_LSB);

    slave_state_t              state_q, state_d;
    logic                      last_grant_wr;
    logic [ID_WIDTH-1:0]       id_q;

    logic                      grant_wr;
    logic                      aw_hs, ar_hs, w_beat, r_hs, b_hs;
    logic                      aw_err, ar_err;

    logic                      ag_load, ag_step, ag_set_err;
    logic [MEM_ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]                ld_len;
    logic [1:0]                ld_burst;
    logic                      ld_err;
    logic [MEM_ADDR_WIDTH-1:0] ag_addr, ag_addr_next;
    logic                      ag_last, ag_over, ag_err;

    logic                      unused_bits;
    assign unused_bits = ^{axi_wid, axi_awaddr, axi_araddr};

    // ---------------- arbitration and handshakes ----------------
    assign grant_wr    = axi_awvalid & (~axi_arvalid | ~last_grant_wr);
    assign axi_awready = i_axi_rst & (state_q == ST_IDLE) & grant_wr;
    assign axi_arready = i_axi_rst & (state_q == ST_IDLE) & axi_arvalid & ~grant_wr;
    assign axi_wready  = (state_q == ST_WR_DATA);
    assign axi_bvalid  = (state_q == ST_WR_RESP);
    assign axi_rvalid  = (state_q == ST_RD_SEND);

    assign aw_hs  = axi_awvalid & axi_awready;
    assign ar_hs  = axi_arvalid & axi_arready;
    assign w_beat = axi_wvalid & axi_wready;
    assign b_hs   = axi_bvalid & axi_bready;
    assign r_hs   = axi_rvalid & axi_rready;

    assign aw_err = (axi_awburst >= BURST_WRAP) | (axi_awsize != FULL_SIZE);
    assign ar_err = (axi_arburst >= BURST_WRAP) | (axi_arsize != FULL_SIZE);

    // ---------------- address generator ----------------
    assign ag_load  = aw_hs | ar_hs;
    assign ld_addr  = aw_hs ? axi_awaddr[ADDR_LSB +: MEM_ADDR_WIDTH]
                            : axi_araddr[ADDR_LSB +: MEM_ADDR_WIDTH];
    assign ld_len   = aw_hs ? axi_awlen   : axi_arlen;
    assign ld_burst = aw_hs ? axi_awburst : axi_arburst;
    assign ld_err   = aw_hs ? aw_err      : ar_err;

    // The final read beat needs no advance; the next AR reloads anyway.
    assign ag_step    = w_beat | (r_hs & ~ag_last);
    // wlast early (before beat len) or missing on beat len.
    assign ag_set_err = w_beat & ((axi_wlast & ~ag_last & ~ag_over) | (ag_last & ~axi_wlast));

    axi_burst_addr_gen #(
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_addr_gen (
        .i_axi_clk  (i_axi_clk),
        .i_axi_rst  (i_axi_rst),
        .load       (ag_load),
        .load_addr  (ld_addr),
        .load_len   (ld_len),
        .load_burst (ld_burst),
        .load_err   (ld_err),
        .step       (ag_step),
        .set_err    (ag_set_err),
        .addr       (ag_addr),
        .addr_next  (ag_addr_next),
        .last       (ag_last),
        .over       (ag_over),
        .err        (ag_err)
    );

    // ---------------- response channels ----------------
    assign axi_bid   = id_q;
    assign axi_rid   = id_q;
    assign axi_bresp = ((state_q == ST_WR_RESP) && ag_err) ? RESP_SLVERR : RESP_OKAY;
    assign axi_rresp = ((state_q == ST_RD_SEND) && ag_err) ? RESP_SLVERR : RESP_OKAY;
    assign axi_rlast = (state_q == ST_RD_SEND) & ag_last;
    assign axi_rdata = ((state_q == ST_RD_SEND) && !ag_err) ? i_mem_rdata : '0;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    state_d = ST_WR_DATA;
                end else if (ar_hs) begin
                    state_d = ST_RD_FETCH;
                end
            end
            ST_WR_DATA: begin
                if (w_beat && axi_wlast) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_FETCH: begin
                state_d = ST_RD_SEND;
            end
            ST_RD_SEND: begin
                if (r_hs) begin
                    state_d = ag_last ? ST_IDLE : ST_RD_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            state_q       <= ST_IDLE;
            last_grant_wr <= 1'b0;
            id_q          <= '0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                id_q <= axi_awid;
            end else if (ar_hs) begin
                id_q <= axi_arid;
            end
            if (b_hs) begin
                last_grant_wr <= 1'b1;
            end else if (r_hs && ag_last) begin
                last_grant_wr <= 1'b0;
            end
        end
    end

    // ---------------- RAM port ----------------
    // The read address is presented on entry to RD_FETCH (from AR directly, or
    // from addr_next on a non-final read beat) so RAM data lands in RD_SEND and
    // stays stable while the address is held.
    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            o_mem_wen   <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_mem_wen <= '0;
            if (w_beat) begin
                o_mem_wen   <= (ag_err || ag_over) ? '0 : axi_wstrb;
                o_mem_addr  <= ag_addr;
                o_mem_wdata <= axi_wdata;
            end else if (ar_hs) begin
                o_mem_addr <= axi_araddr[ADDR_LSB +: MEM_ADDR_WIDTH];
            end else if (r_hs && !ag_last) begin
                o_mem_addr <= ag_addr_next;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
module tb_axi_burst_mem_slave;
    import axi_defs_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        i_axi_rst = 1'b0;
    logic [31:0] axi_awaddr = '0;
    logic [3:0]  axi_awid = '0;
    logic [7:0]  axi_awlen = '0;
    logic [2:0]  axi_awsize = '0;
    logic [1:0]  axi_awburst = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wid = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wlast = 1'b0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic [3:0]  axi_bid;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [31:0] axi_araddr = '0;
    logic [3:0]  axi_arid = '0;
    logic [7:0]  axi_arlen = '0;
    logic [2:0]  axi_arsize = '0;
    logic [1:0]  axi_arburst = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [3:0]  axi_rid;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [3:0]  o_mem_wen;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        fill = 1'b1;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    always #5 clk = ~clk;

    axi_burst_mem_slave #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .ID_WIDTH       (4),
        .MEM_ADDR_WIDTH (10)
    ) dut (
        .i_axi_clk   (clk),
        .i_axi_rst   (i_axi_rst),
        .axi_awaddr  (axi_awaddr),
        .axi_awid    (axi_awid),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wid     (axi_wid),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bid     (axi_bid),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arid    (axi_arid),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rid     (axi_rid),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .o_mem_wen   (o_mem_wen),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] fill_val(input int i);
        return (32'(i) * 32'h0001_0003) ^ 32'hC3A5_0000;
    endfunction

    // Single-port synchronous RAM attached to the slave.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= fill_val(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (o_mem_wen[b]) ram[o_mem_addr][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
        end
        mem_rdata <= ram[o_mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic bit txn_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size != 3'd2);
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a, input int i, input logic [1:0] burst);
        int unsigned base = a[11:2];
        return (base + ((burst == BURST_FIXED) ? 0 : i)) % DEPTH;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                               input logic [2:0] size, input int nbeats);
        if (!txn_err(burst, size) && nbeats == int'(len) + 1)
            for (int i = 0; i < nbeats; i++) begin
                int unsigned w = word_of(a, i, burst);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[w][b*8 +: 8] = wd[i][b*8 +: 8];
            end
    endtask

    // ---------------- channel drivers ----------------
    task automatic reset_dut();
        @(negedge clk);
        i_axi_rst = 1'b0;
        axi_awvalid = 1'b0; axi_arvalid = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0;  axi_rready = 1'b0;
        repeat (2) @(negedge clk);
        i_axi_rst = 1'b1;
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id);
        bit ok = 1'b0;
        @(negedge clk);
        axi_awaddr = a; axi_awlen = len; axi_awburst = burst; axi_awsize = size;
        axi_awid = id; axi_awvalid = 1'b1;
        for (int g = 0; g < 50; g++) begin
            #1;
            if (axi_awready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        axi_awvalid = 1'b0;
        chk("aw_accept", ok, 1);
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id);
        bit ok = 1'b0;
        @(negedge clk);
        axi_araddr = a; axi_arlen = len; axi_arburst = burst; axi_arsize = size;
        axi_arid = id; axi_arvalid = 1'b1;
        for (int g = 0; g < 50; g++) begin
            #1;
            if (axi_arready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        axi_arvalid = 1'b0;
        chk("ar_accept", ok, 1);
    endtask

    task automatic w_phase(input int nbeats);
        int i = 0;
        int guard = 0;
        while (i < nbeats && guard < 200) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(0, 3) == 0) begin
                axi_wvalid = 1'b0;
                continue;
            end
            axi_wvalid = 1'b1;
            axi_wdata  = wd[i];
            axi_wstrb  = ws[i];
            axi_wlast  = (i == nbeats - 1);
            axi_wid    = 4'($urandom);
            #1;
            if (axi_wready) i++;
        end
        @(negedge clk);
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        chk("w_beats", i, nbeats);
    endtask

    task automatic b_phase(input logic [3:0] id, input logic [1:0] resp);
        bit done = 1'b0;
        bit seen = 1'b0;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clk);
            axi_bready = 1'($urandom_range(0, 1));
            #1;
            if (seen) chk("b_hold", axi_bvalid, 1);
            if (axi_bvalid) begin
                if (axi_bready) begin
                    chk("b_id", axi_bid, id);
                    chk("b_resp", axi_bresp, resp);
                    done = 1'b1;
                end else begin
                    seen = 1'b1;
                end
            end
        end
        @(negedge clk);
        axi_bready = 1'b0;
        #1;
        chk("b_done", done, 1);
        chk("b_drop", axi_bvalid, 0);
    endtask

    // mode 0: rready always high, 1: toggling, 2: random.
    // abort_at >= 0 returns as soon as that beat is presented, without taking it.
    task automatic r_phase(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input int mode, input int abort_at);
        int beat = 0;
        int guard = 0;
        bit held = 1'b0;
        logic [63:0] snap = '0;
        bit e = txn_err(burst, size);
        while (beat <= int'(len) && guard < 400) begin
            @(negedge clk);
            guard++;
            axi_rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(guard % 2) : 1'($urandom_range(0, 1));
            #1;
            if (held) begin
                chk("r_stable", {axi_rvalid, axi_rdata, axi_rlast, axi_rresp, axi_rid}, snap);
                held = 1'b0;
            end
            if (axi_rvalid) begin
                if (beat == abort_at) begin
                    axi_rready = 1'b0;
                    return;
                end
                if (axi_rready) begin
                    chk("r_data", axi_rdata, e ? 32'h0 : ref_mem[word_of(a, beat, burst)]);
                    chk("r_id", axi_rid, id);
                    chk("r_resp", axi_rresp, e ? RESP_SLVERR : RESP_OKAY);
                    chk("r_last", axi_rlast, beat == int'(len));
                    beat++;
                end else begin
                    held = 1'b1;
                    snap = {24'h0, axi_rvalid, axi_rdata, axi_rlast, axi_rresp, axi_rid};
                end
            end
        end
        @(negedge clk);
        axi_rready = 1'b0;
        chk("r_beats", beat, int'(len) + 1);
    endtask

    task automatic wr_txn(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input int nbeats);
        bit bad = txn_err(burst, size) || (nbeats != int'(len) + 1);
        aw_phase(a, len, burst, size, id);
        w_phase(nbeats);
        model_write(a, len, burst, size, nbeats);
        b_phase(id, bad ? RESP_SLVERR : RESP_OKAY);
    endtask

    task automatic rd_txn(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input int mode);
        ar_phase(a, len, burst, size, id);
        r_phase(a, len, burst, size, id, mode, -1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nbad;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_val(i);

        // ---- reset state ----
        repeat (3) @(negedge clk);
        fill = 1'b0;
        #1;
        chk("rst_ready_valid", {axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid}, 0);
        chk("rst_mem_wen", o_mem_wen, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        chk("rst_resp_id", {axi_bresp, axi_rresp, axi_bid, axi_rid, axi_rlast}, 0);
        @(negedge clk);
        i_axi_rst = 1'b1;

        // ---- INCR write of words 4..7 ----
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        wr_txn(32'h10, 8'd3, BURST_INCR, 3'd2, 4'd5, 4);
        chk("ram_w4", ram[4], 32'hA0);
        chk("ram_w5", ram[5], 32'hA1);
        chk("ram_w6", ram[6], 32'hA2);
        chk("ram_w7", ram[7], 32'hA3);

        // ---- INCR read back, steady and toggling rready ----
        rd_txn(32'h10, 8'd3, BURST_INCR, 3'd2, 4'd9, 0);
        rd_txn(32'h10, 8'd3, BURST_INCR, 3'd2, 4'd9, 1);

        // ---- partial strobe ----
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        wr_txn(32'h50, 8'd0, BURST_INCR, 3'd2, 4'd1, 1);
        wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
        wr_txn(32'h50, 8'd0, BURST_INCR, 3'd2, 4'd1, 1);
        chk("ram_strobe", ram[20], 32'hFF22_FF44);
        rd_txn(32'h50, 8'd0, BURST_INCR, 3'd2, 4'd2, 2);

        // ---- address wrap at the top of the RAM ----
        wd[0] = 32'hB0; wd[1] = 32'hB1; ws[0] = 4'hF; ws[1] = 4'hF;
        wr_txn(32'hFFC, 8'd1, BURST_INCR, 3'd2, 4'd3, 2);
        chk("ram_wrap_top", ram[1023], 32'hB0);
        chk("ram_wrap_zero", ram[0], 32'hB1);

        // ---- error: WRAP burst writes nothing ----
        wd[0] = 32'hDEAD_0000; wd[1] = 32'hDEAD_0001; ws[0] = 4'hF; ws[1] = 4'hF;
        wr_txn(32'h100, 8'd1, BURST_WRAP, 3'd2, 4'd4, 2);
        chk("ram_err_w64", ram[64], fill_val(64));
        chk("ram_err_w65", ram[65], fill_val(65));

        // ---- error: wlast on beat 0 of a 3-beat burst, then a clean overwrite ----
        wd[0] = 32'h0BAD_0BAD; ws[0] = 4'hF;
        wr_txn(32'h200, 8'd2, BURST_INCR, 3'd2, 4'd7, 1);
        wd[0] = 32'h600D_0128; ws[0] = 4'hF;
        wr_txn(32'h200, 8'd0, BURST_INCR, 3'd2, 4'd8, 1);
        chk("ram_after_err", ram[128], 32'h600D_0128);

        // ---- error: narrow read size returns zeros with SLVERR ----
        rd_txn(32'h10, 8'd2, BURST_INCR, 3'd0, 4'd6, 2);

        // ---- arbitration after reset: write first, then the next tie goes to read ----
        reset_dut();
        @(negedge clk);
        axi_awaddr = 32'h300; axi_awlen = 8'd0; axi_awid = 4'd1; axi_awburst = BURST_INCR;
        axi_awsize = 3'd2; axi_awvalid = 1'b1;
        axi_araddr = 32'h300; axi_arlen = 8'd0; axi_arid = 4'd2; axi_arburst = BURST_INCR;
        axi_arsize = 3'd2; axi_arvalid = 1'b1;
        #1;
        chk("arb1_awready", axi_awready, 1);
        chk("arb1_arready", axi_arready, 0);
        @(negedge clk);
        axi_awvalid = 1'b0;
        wd[0] = 32'hC0C0_0001; ws[0] = 4'hF;
        w_phase(1);
        model_write(32'h300, 8'd0, BURST_INCR, 3'd2, 1);
        axi_awaddr = 32'h304; axi_awid = 4'd3; axi_awvalid = 1'b1;
        #1;
        chk("arb_busy_aw", axi_awready, 0);
        chk("arb_busy_ar", axi_arready, 0);
        b_phase(4'd1, RESP_OKAY);
        chk("arb2_arready", axi_arready, 1);
        chk("arb2_awready", axi_awready, 0);
        @(negedge clk);
        axi_arvalid = 1'b0;
        r_phase(32'h300, 8'd0, BURST_INCR, 3'd2, 4'd2, 0, -1);
        #1;
        chk("arb3_awready", axi_awready, 1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        wd[0] = 32'hC0C0_0002; ws[0] = 4'hF;
        w_phase(1);
        model_write(32'h304, 8'd0, BURST_INCR, 3'd2, 1);
        b_phase(4'd3, RESP_OKAY);

        // ---- reset during beat 2 of a 4-beat read ----
        ar_phase(32'h10, 8'd3, BURST_INCR, 3'd2, 4'd6);
        r_phase(32'h10, 8'd3, BURST_INCR, 3'd2, 4'd6, 0, 2);
        i_axi_rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_rvalid", axi_rvalid, 0);
        chk("rst_mid_ready", {axi_arready, axi_awready}, 0);
        i_axi_rst = 1'b1;
        rd_txn(32'h10, 8'd3, BURST_INCR, 3'd2, 4'd10, 2);

        // ---- randomized traffic ----
        for (int t = 0; t < 30; t++) begin
            logic [31:0] a = $urandom;
            logic [7:0]  len = 8'($urandom_range(0, 7));
            logic [3:0]  id = 4'($urandom);
            int          r = $urandom_range(0, 9);
            logic [1:0]  burst = (r < 6) ? BURST_INCR : (r < 8) ? BURST_FIXED : (r == 8) ? BURST_WRAP : 2'b11;
            logic [2:0]  size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                wr_txn(a, len, burst, size, id, int'(len) + 1);
            end else begin
                rd_txn(a, len, burst, size, id, 2);
            end
        end

        // ---- whole RAM against the model ----
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) nbad++;
        chk("ram_final", nbad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
